jesd204b_tpl_tx_mapper: RTL and testbench
=========================================

Name: jesd204b_tpl_tx_mapper

Overview:
Parametrised JESD204B transmit transport-layer mapper, the successor to the fixed-geometry TX mapper. It packs S samples from each of M converters, with per-sample control bits and zero tails, into F octets per lane across L lanes. It adds valid/ready flow control and multiframe (K) tracking with start-of-frame and start-of-multiframe flags. It sits between the converter sample interface and the TX data link layer.

Parameters:
L, 4, lanes in the link (1..8)
M, 8, converters (1..32)
N, 11, converter resolution in bits
CS, 2, control bits per sample
NP, 16, N' bits per sample word; NP >= N+CS, elaboration error otherwise
S, 1, samples per converter per frame
K, 32, frames per multiframe (1..32)
Derived localparams: CPL = ceil(M/L) converters per lane; M_PAD = CPL*L; T = NP-N-CS tail bits; F = S*NP*CPL/8 octets per lane per frame. Elaboration error if S*NP*CPL is not a multiple of 8.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
en  in  1  link enable
s_valid  in  1  input frame valid
s_ready  out  1  input frame accepted when s_valid&&s_ready
s_data  in  S*M*N  sample of converter c, index s, at [(c*S+s)*N +: N]
s_ctrl  in  S*M*CS  control bits for (c,s) at [(c*S+s)*CS +: CS]
m_valid  out  1  output frame valid
m_ready  in  1  downstream accepts when m_valid&&m_ready
m_data  out  L*F*8  lane l at [l*F*8 +: F*8]; octet 0 in the most-significant byte of the lane slice
m_sof  out  1  high with every valid frame (F-aligned beat marker)
m_somf  out  1  high when the output frame is frame 0 of the multiframe
frame_cnt  out  clog2(K) (min 1)  index of the current output frame within the multiframe

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_sof=0, m_somf=0, frame_cnt=0. s_ready=0 while reset_n=0.
- Sample word for (c,s) = {s_data[N bits], s_ctrl[CS bits], T zeros}, MSB-first.
- Lane l carries converters l*CPL .. l*CPL+CPL-1 in ascending order; each converter contributes samples s=0..S-1 in order; words are concatenated MSB-first starting at octet 0.
- Converters M..M_PAD-1 are padding: their words are all-zero.
- Pipeline: one output register stage; latency 1 clk from accept to m_valid.
- s_ready = en && (!m_valid || m_ready). This is combinational from registered state, with no bubble at full throughput.
- On accept: m_data is loaded with the mapped frame, m_valid=1, m_sof=1, m_somf=(next frame index==0).
- When m_valid && !m_ready: m_data, m_sof, m_somf and frame_cnt are held stable.
- On output transfer with no new accept: m_valid=0.
- frame_cnt advances on each output transfer and wraps from K-1 to 0. With K=1, m_somf=1 on every frame.
- en=0: no new accepts. A frame already in the output register is still delivered. Once the output is empty, frame_cnt clears to 0, so the next frame after re-enable is a multiframe start.
- Reset mid-frame: the pending output is discarded and there is no partial transfer.

Optional Feature:
- Macro: TPL_TX_TEST_PATTERN_EN.
- When defined:
  - Adds input tpat_en (1 bit).
  - While tpat_en=1, s_data is ignored and sample (c,s) is replaced with (ramp + c*S + s) mod 2^N.
  - ramp is an N-bit register, reset to 0, incremented by S on each accept.
  - s_ctrl is still used.
- When undefined: no port and no logic; the data path is identical to tpat_en=0.

Decomposition:
- Package jesd204b_tx_pkg holds:
  - the derived-geometry functions (CPL, M_PAD, F, tail count);
  - a clog2 helper;
  - the sample-word assembly function.
- One sub-module, jesd204b_tpl_lane_pack: a purely combinational packer for one lane, instantiated L times by a generate loop.
- The top level owns the handshake, the output register and the frame counter.

Test Plan:
- Default parameters; converter 0 = 11'h7FF, ctrl 2'b10; converter 1 = 11'h001, ctrl 0 -> after 1 clk, m_data[31:16]=16'hFFF0 and m_data[15:0]=16'h0020.
- M=6, L=4 (CPL=2, F=4); all samples 11'h7FF, ctrl 0 -> lanes 0-2 = 32'hFFE0FFE0, lane 3 = 32'h0.
- K=4, continuous valid/ready for 9 frames -> m_somf high on frames 0, 4 and 8; frame_cnt sequence 0,1,2,3,0,...
- m_ready low for 3 cycles with s_valid held high -> m_data stable and s_ready=0 throughout; no frame lost or duplicated (check with a scoreboard).
- en dropped while a frame is pending -> the pending frame is delivered, then frame_cnt=0; the first frame after re-enable has m_somf=1.
- reset_n pulsed low mid-stream -> outputs zero immediately, with no clk edge needed; the first frame after release has frame_cnt=0. With TPL_TX_TEST_PATTERN_EN defined, the ramp restarts at 0.

Source files
------------

// File: rtl/jesd204b_tx_pkg.sv
// Shared geometry helpers and sample-word assembly for the JESD204B TX transport-layer mapper.
package jesd204b_tx_pkg;

    function automatic int cpl_f(input int m, input int l);
        return (m + l - 32'sd1) / l;
    endfunction

    function automatic int m_pad_f(input int m, input int l);
        return cpl_f(m, l) * l;
    endfunction

    function automatic int tail_f(input int np, input int n, input int cs);
        return np - n - cs;
    endfunction

    function automatic int f_octets_f(input int s, input int np, input int cpl);
        return (s * np * cpl) / 32'sd8;
    endfunction

    // Ceiling log2 with a floor of 1 so single-value counters still get a bit.
    function automatic int clog2_f(input int v);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return (r < 32'sd1) ? 32'sd1 : r;
    endfunction

    // {sample, ctrl, zero tail} right-aligned in 64 bits; callers cast down to NP.
    function automatic logic [63:0] sample_word(input logic [63:0] data, input logic [63:0] ctrl,
                                                input int n, input int cs, input int np);
        logic [63:0] mask_n;
        logic [63:0] mask_cs;
        int          t;
        t       = tail_f(np, n, cs);
        mask_n  = (64'd1 << n) - 64'd1;
        mask_cs = (64'd1 << cs) - 64'd1;
        return ((data & mask_n) << (cs + t)) | ((ctrl & mask_cs) << t);
    endfunction

endpackage

// File: rtl/jesd204b_tpl_lane_pack.sv
// Combinational packer for one lane: CPL converters x S samples, word 0 in the most-significant position.
module jesd204b_tpl_lane_pack
    import jesd204b_tx_pkg::*;
#(
    parameter int N   = 11,
    parameter int CS  = 2,
    parameter int NP  = 16,
    parameter int S   = 1,
    parameter int CPL = 2
) (
    input  logic [S*CPL*N-1:0]  s_data,
    input  logic [S*CPL*CS-1:0] s_ctrl,
    output logic [S*CPL*NP-1:0] lane
);

    localparam int WPL = S * CPL;

    genvar k, s;
    generate
        for (k = 0; k < CPL; k++) begin : g_conv
            for (s = 0; s < S; s++) begin : g_smp
                localparam int W   = k * S + s;
                localparam int POS = (WPL - 1 - W) * NP;
                assign lane[POS +: NP] = NP'(sample_word(64'(s_data[W*N +: N]), 64'(s_ctrl[W*CS +: CS]),
                                                         N, CS, NP));
            end
        end
    endgenerate

endmodule

// File: rtl/jesd204b_tpl_tx_mapper.sv
// JESD204B TX transport-layer mapper: handshake, output register and multiframe counter.
// Optional build macro TPL_TX_TEST_PATTERN_EN adds a ramp test-pattern source (tpat_en).
module jesd204b_tpl_tx_mapper
    import jesd204b_tx_pkg::*;
#(
    parameter int L  = 4,
    parameter int M  = 8,
    parameter int N  = 11,
    parameter int CS = 2,
    parameter int NP = 16,
    parameter int S  = 1,
    parameter int K  = 32
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        en,
`ifdef TPL_TX_TEST_PATTERN_EN
    input  logic                                        tpat_en,
`endif
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [S*M*N-1:0]                            s_data,
    input  logic [S*M*CS-1:0]                           s_ctrl,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [L*f_octets_f(S, NP, cpl_f(M, L))*8-1:0] m_data,
    output logic                                        m_sof,
    output logic                                        m_somf,
    output logic [clog2_f(K)-1:0]                       frame_cnt
);

    localparam int CPL   = cpl_f(M, L);
    localparam int M_PAD = m_pad_f(M, L);
    localparam int F     = f_octets_f(S, NP, CPL);
    localparam int FW    = clog2_f(K);
    localparam int LW    = F * 8;

    generate
        if (NP < N + CS) begin : g_err_np
            $error("jesd204b_tpl_tx_mapper: NP must be >= N+CS");
        end
        if (((S * NP * CPL) % 8) != 0) begin : g_err_oct
            $error("jesd204b_tpl_tx_mapper: S*NP*CPL must be a multiple of 8");
        end
    endgenerate

    logic [S*M*N-1:0]      data_s;
    logic [S*M_PAD*N-1:0]  data_pad_s;
    logic [S*M_PAD*CS-1:0] ctrl_pad_s;
    logic [L*LW-1:0]       mapped_s;
    logic                  s_ready_s;
    logic                  accept_s;
    logic                  xfer_s;
    logic [FW-1:0]         frame_inc_s;
    logic [FW-1:0]         next_idx_s;
    logic                  m_valid_r;
    logic [L*LW-1:0]       m_data_r;
    logic                  m_sof_r;
    logic                  m_somf_r;
    logic [FW-1:0]         frame_cnt_r;

`ifdef TPL_TX_TEST_PATTERN_EN
    logic [N-1:0] ramp_r;

    genvar c, s;
    generate
        for (c = 0; c < M; c++) begin : g_tp_conv
            for (s = 0; s < S; s++) begin : g_tp_smp
                assign data_s[(c*S+s)*N +: N] = tpat_en ? (ramp_r + N'(c * S + s))
                                                        : s_data[(c*S+s)*N +: N];
            end
        end
    endgenerate

    // Ramp seed advances by S per accepted frame so the pattern is continuous per converter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp_r <= {N{1'b0}};
        end else if (accept_s) begin
            ramp_r <= ramp_r + N'(S);
        end else begin
            ramp_r <= ramp_r;
        end
    end
`else
    assign data_s = s_data;
`endif

    // Padding converters beyond M become all-zero words through zero extension.
    assign data_pad_s = (S*M_PAD*N)'(data_s);
    assign ctrl_pad_s = (S*M_PAD*CS)'(s_ctrl);

    genvar l;
    generate
        for (l = 0; l < L; l++) begin : g_lane
            jesd204b_tpl_lane_pack #(
                .N   (N),
                .CS  (CS),
                .NP  (NP),
                .S   (S),
                .CPL (CPL)
            ) u_lane_pack (
                .s_data (data_pad_s[l*S*CPL*N +: S*CPL*N]),
                .s_ctrl (ctrl_pad_s[l*S*CPL*CS +: S*CPL*CS]),
                .lane   (mapped_s[l*LW +: LW])
            );
        end
    endgenerate

    assign s_ready_s   = reset_n && en && (!m_valid_r || m_ready);
    assign accept_s    = s_valid && s_ready_s;
    assign xfer_s      = m_valid_r && m_ready;
    assign frame_inc_s = (frame_cnt_r == FW'(K - 1)) ? {FW{1'b0}} : (frame_cnt_r + FW'(1'b1));
    // A frame loaded while the previous one leaves takes the following index.
    assign next_idx_s  = xfer_s ? frame_inc_s : frame_cnt_r;

    // Output register stage and multiframe position tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_r   <= 1'b0;
            m_data_r    <= {(L*LW){1'b0}};
            m_sof_r     <= 1'b0;
            m_somf_r    <= 1'b0;
            frame_cnt_r <= {FW{1'b0}};
        end else begin
            if (accept_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= mapped_s;
                m_sof_r   <= 1'b1;
                m_somf_r  <= (next_idx_s == {FW{1'b0}});
            end else if (xfer_s) begin
                m_valid_r <= 1'b0;
                m_sof_r   <= 1'b0;
                m_somf_r  <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
                m_sof_r   <= m_sof_r;
                m_somf_r  <= m_somf_r;
            end
            if (xfer_s) begin
                frame_cnt_r <= frame_inc_s;
            end else if (!m_valid_r && !en) begin
                frame_cnt_r <= {FW{1'b0}};
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign s_ready   = s_ready_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign m_sof     = m_sof_r;
    assign m_somf    = m_somf_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_jesd204b_tpl_tx_mapper.sv
// Directed bench: default-geometry instance for the word layout, M=6/K=4 instance scoreboarded.
module tb_jesd204b_tpl_tx_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, en, s_valid, m_ready, tpat;

    logic [87:0]  s_data0;
    logic [15:0]  s_ctrl0;
    logic         s_ready0, m_valid0, m_sof0, m_somf0;
    logic [127:0] m_data0;
    logic [4:0]   frame_cnt0;

    logic [65:0]  s_data1;
    logic [11:0]  s_ctrl1;
    logic         s_ready1, m_valid1, m_sof1, m_somf1;
    logic [127:0] m_data1;
    logic [1:0]   frame_cnt1;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] sb_q[$];
    int mf_idx = 0;
    int tb_ramp = 0;

    jesd204b_tpl_tx_mapper u_dut0 (
        .clk (clk), .reset_n (reset_n), .en (en),
`ifdef TPL_TX_TEST_PATTERN_EN
        .tpat_en (tpat),
`endif
        .s_valid (s_valid), .s_ready (s_ready0), .s_data (s_data0), .s_ctrl (s_ctrl0),
        .m_valid (m_valid0), .m_ready (m_ready), .m_data (m_data0),
        .m_sof (m_sof0), .m_somf (m_somf0), .frame_cnt (frame_cnt0)
    );

    jesd204b_tpl_tx_mapper #(.L(4), .M(6), .N(11), .CS(2), .NP(16), .S(1), .K(4)) u_dut1 (
        .clk (clk), .reset_n (reset_n), .en (en),
`ifdef TPL_TX_TEST_PATTERN_EN
        .tpat_en (tpat),
`endif
        .s_valid (s_valid), .s_ready (s_ready1), .s_data (s_data1), .s_ctrl (s_ctrl1),
        .m_valid (m_valid1), .m_ready (m_ready), .m_data (m_data1),
        .m_sof (m_sof1), .m_somf (m_somf1), .frame_cnt (frame_cnt1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // M=6, L=4: two converters per lane, converter 2l at lane bits [31:16], 2l+1 at [15:0].
    function automatic logic [127:0] map6(input logic [65:0] d, input logic [11:0] c);
        logic [127:0] r;
        r = '0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int k = 0; k < 2; k++) begin
                int cv;
                cv = ln * 2 + k;
                if (cv < 6) r[ln*32 + (1-k)*16 +: 16] = {d[cv*11 +: 11], c[cv*2 +: 2], 3'b000};
            end
        end
        return r;
    endfunction

    function automatic logic [65:0] eff_data(input logic [65:0] d, input logic tp, input int ramp);
        logic [65:0] r;
        r = d;
        if (tp) begin
            for (int cv = 0; cv < 6; cv++) r[cv*11 +: 11] = 11'(ramp + cv);
        end
        return r;
    endfunction

    // Scoreboard: pop and compare on every output transfer, push on every accept.
    always @(negedge clk) begin : mon
        logic [127:0] exp_d;
        if (reset_n && m_valid1 && m_ready) begin
            chk("sb_nonempty", 128'(sb_q.size() > 0), 128'(1));
            if (sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                chk("out_data", m_data1, exp_d);
                chk("out_sof", 128'(m_sof1), 128'(1));
                chk("out_somf", 128'(m_somf1), 128'(mf_idx == 0));
                chk("out_frame_cnt", 128'(frame_cnt1), 128'(mf_idx));
            end
            mf_idx = (mf_idx + 1) % 4;
        end
        if (reset_n && s_valid && s_ready1) begin
            sb_q.push_back(map6(eff_data(s_data1, tpat, tb_ramp), s_ctrl1));
            tb_ramp = tb_ramp + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rnd();
        s_data1 = 66'({$urandom(), $urandom(), $urandom()});
        s_ctrl1 = 12'($urandom());
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; s_valid = 1'b0; m_ready = 1'b0; tpat = 1'b0;
        s_data0 = '0; s_ctrl0 = '0; s_data1 = '0; s_ctrl1 = '0;
        cyc(2);
        chk("rst_m_valid", 128'(m_valid1), 128'(0));
        chk("rst_m_data", m_data1, 128'(0));
        chk("rst_m_sof", 128'(m_sof1), 128'(0));
        chk("rst_m_somf", 128'(m_somf1), 128'(0));
        chk("rst_frame_cnt", 128'(frame_cnt1), 128'(0));
        chk("rst_s_ready", 128'(s_ready1), 128'(0));

        // Word layout: default geometry and the padded M=6 geometry
        reset_n = 1'b1; m_ready = 1'b1;
        s_data0[10:0] = 11'h7FF; s_data0[21:11] = 11'h001; s_ctrl0[1:0] = 2'b10;
        s_data1 = {6{11'h7FF}}; s_ctrl1 = 12'h000;
        s_valid = 1'b1;
        cyc(1);
        s_valid = 1'b0;
        chk("def_conv0", 128'(m_data0[31:16]), 128'(16'hFFF0));
        chk("def_conv1", 128'(m_data0[15:0]), 128'(16'h0020));
        chk("m6_lanes", m_data1, {32'h0, 32'hFFE0FFE0, 32'hFFE0FFE0, 32'hFFE0FFE0});
        chk("first_somf", 128'(m_somf1), 128'(1));

        // Continuous streaming across multiframe boundaries
        cyc(2);
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rnd();
            cyc(1);
        end
        s_valid = 1'b0;

        // Backpressure: three stalled cycles with s_valid held
        cyc(3);
        m_ready = 1'b0; s_valid = 1'b1; rnd();
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_s_ready", 128'(s_ready1), 128'(0));
            chk("stall_m_valid", 128'(m_valid1), 128'(1));
            chk("stall_m_data", m_data1, (sb_q.size() > 0) ? sb_q[0] : 128'hx);
            cyc(1);
        end
        m_ready = 1'b1;
        cyc(1);
        rnd(); cyc(1);
        rnd(); cyc(1);
        s_valid = 1'b0;

        // Link disable with a frame pending
        cyc(3);
        m_ready = 1'b0; s_valid = 1'b1; rnd();
        cyc(1);
        en = 1'b0; s_valid = 1'b0;
        cyc(2);
        chk("en_off_hold", 128'(m_valid1), 128'(1));
        chk("en_off_s_ready", 128'(s_ready1), 128'(0));
        m_ready = 1'b1;
        cyc(3);
        chk("en_off_empty", 128'(m_valid1), 128'(0));
        chk("en_off_cnt", 128'(frame_cnt1), 128'(0));
        mf_idx = 0;
        en = 1'b1; s_valid = 1'b1; rnd();
        cyc(1);
        s_valid = 1'b0;
        chk("reen_somf", 128'(m_somf1), 128'(1));
        chk("reen_cnt", 128'(frame_cnt1), 128'(0));

        // Asynchronous reset in the middle of a stream
        cyc(2);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd();
            cyc(1);
        end
        reset_n = 1'b0;
        sb_q.delete();
        tb_ramp = 0;
        #1;
        chk("arst_m_valid", 128'(m_valid1), 128'(0));
        chk("arst_m_data", m_data1, 128'(0));
        chk("arst_m_sof", 128'(m_sof1), 128'(0));
        chk("arst_m_somf", 128'(m_somf1), 128'(0));
        chk("arst_frame_cnt", 128'(frame_cnt1), 128'(0));
        chk("arst_s_ready", 128'(s_ready1), 128'(0));
        s_valid = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        mf_idx = 0;
`ifdef TPL_TX_TEST_PATTERN_EN
        tpat = 1'b1;
`endif
        s_valid = 1'b1;
        rnd(); cyc(1);
        chk("post_rst_cnt", 128'(frame_cnt1), 128'(0));
        rnd(); cyc(1);
        s_valid = 1'b0;

        // Drain with a bounded wait
        cyc(1);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) cyc(1);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
